load_store_unit: RTL and testbench

- Datapath-side initiator for the 32-word data memory. It turns one load/store request from the multicycle core into word-wide memory read/write cycles.
- Supports RISC-V lb/lh/lw/lbu/lhu/sb/sh/sw: effective-address computation, alignment/range checks, sign/zero extension, and read-modify-write for sub-word stores.
- Sits between the execute-stage registers and the data memory; the memory registers its read data on clk.

---
 rtl/lsu_pkg.sv | 52 +++++
 rtl/lsu_align.sv | 47 ++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state encoding and access checking for the load/store unit
//
// Purpose : funct3 encodings, FSM state type, response error codes and the
//           request legality check used by load_store_unit.
// Ports   : none (package).

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // Error classification in priority order: illegal, misaligned, out of range.
  function automatic logic [1:0] check_access(input logic       is_store,
                                              input logic [2:0] funct3,
                                              input logic [1:0] offset,
                                              input logic       out_of_range);
    logic illegal;
    logic misaligned;
    if (is_store)
      illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
    else
      illegal = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
    // funct3[1:0] selects size for both signed and unsigned variants
    misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                 ((funct3[1:0] == 2'b10) && (offset != 2'b00));
    if (illegal)
      return ERR_ILLEGAL;
    else if (misaligned)
      return ERR_MISALIGN;
    else if (out_of_range)
      return ERR_RANGE;
    else
      return ERR_OK;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte/half lane extraction for loads and lane merge for sub-word stores
//
// Purpose : purely combinational lane steering.
// Ports   : funct3     - access size/sign
//           offset     - byte offset within the word
//           rdata      - word read from memory
//           store_data - value being stored (low byte/half used for sb/sh)
//           load_data  - extended load result
//           merged     - rdata with the store lane replaced (store_data for sw)

module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{offset, 3'b000} +: 8];
    half_lane = rdata[{offset[1], 4'b0000} +: 16];

    case (funct3)
      F3_B:    load_data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_lane};
      F3_H:    load_data = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_lane};
      default: load_data = rdata;
    endcase

    merged = rdata;
    case (funct3)
      F3_B:    merged[{offset, 3'b000} +: 8]     = store_data[7:0];
      F3_H:    merged[{offset[1], 4'b0000} +: 16] = store_data[15:0];
      default: merged = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store initiator for the 32-word data memory
//
// Purpose : turns one core load/store request into word read / write cycles,
//           with address checks, sign/zero extension and read-modify-write
//           for sub-word stores.
// Ports   : clk, rst (async, active-high)
//           req_valid/req_ready, is_store, funct3, rs1_val, immediate, store_data - request
//           resp_valid, resp_data, resp_err                                    - response
//           mem_addr, mem_wdata, mem_we, mem_re, mem_rdata                      - memory port

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [11:0]      immediate,
  input  logic [XLEN-1:0]  store_data,
  output logic             resp_valid,
  output logic [XLEN-1:0]  resp_data,
  output logic [1:0]       resp_err,
  output logic [IDX_W-1:0] mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic             mem_we,
  output logic             mem_re,
  input  logic [XLEN-1:0]  mem_rdata
);

  state_t state, state_nxt;

  logic [XLEN-1:0]  ea;
  logic [1:0]       req_err;
  logic             accept;

  logic [IDX_W-1:0] idx_r;
  logic [1:0]       off_r;
  logic [2:0]       f3_r;
  logic             st_r;
  logic [XLEN-1:0]  wdata_r;   // store_data on accept, merged word after WAIT
  logic [XLEN-1:0]  rdata_r;
  logic [1:0]       err_r;

  logic [XLEN-1:0]  load_data;
  logic [XLEN-1:0]  merged;

  assign ea      = rs1_val + {{(XLEN-12){immediate[11]}}, immediate};
  assign req_err = check_access(is_store, funct3, ea[1:0], |ea[XLEN-1:IDX_W+2]);
  assign accept  = req_valid && (state == ST_IDLE);

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (f3_r),
    .offset     (off_r),
    .rdata      (mem_rdata),
    .store_data (wdata_r),
    .load_data  (load_data),
    .merged     (merged)
  );

  // State register; async reset also drops mem_we immediately since the
  // strobes are decoded from state alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err != ERR_OK)                 state_nxt = ST_RESP;
          else if (is_store && funct3 == F3_W)   state_nxt = ST_WR;
          else                                   state_nxt = ST_RD;
        end
      end
      ST_RD:   state_nxt = ST_WAIT;
      ST_WAIT: state_nxt = st_r ? ST_WR : ST_RESP;
      ST_WR:   state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch and response registers. Response registers only change
  // on the way into RESP so they hold between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r   <= '0;
      off_r   <= '0;
      f3_r    <= '0;
      st_r    <= 1'b0;
      wdata_r <= '0;
      rdata_r <= '0;
      err_r   <= ERR_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            idx_r   <= ea[IDX_W+1:2];
            off_r   <= ea[1:0];
            f3_r    <= funct3;
            st_r    <= is_store;
            wdata_r <= store_data;
            if (req_err != ERR_OK) begin
              rdata_r <= '0;
              err_r   <= req_err;
            end
          end
        end
        ST_WAIT: begin
          if (st_r) begin
            wdata_r <= merged;
          end else begin
            rdata_r <= load_data;
            err_r   <= ERR_OK;
          end
        end
        ST_WR: begin
          rdata_r <= '0;
          err_r   <= ERR_OK;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      ST_IDLE: req_ready = 1'b1;
      ST_RD: begin
        mem_re   = 1'b1;
        mem_addr = idx_r;
      end
      ST_WR: begin
        mem_we    = 1'b1;
        mem_addr  = idx_r;
        mem_wdata = wdata_r;
      end
      ST_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign resp_data = rdata_r;
  assign resp_err  = err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1_val = '0;
  logic [11:0] immediate = '0;
  logic [31:0] store_data = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata = '0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mem [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  int          we_total = 0;

  // observation record of the last issued request
  int          r_cyc, rv_n, we_n, we_cyc, re_n, re_cyc;
  logic [31:0] r_data, we_data;
  logic [1:0]  r_err;
  logic [4:0]  we_addr, re_addr;
  logic        both_hi, acc_rdy;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .rs1_val(rs1_val),
    .immediate(immediate), .store_data(store_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_total <= we_total + 1;
    end
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic preload(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request; cycle 0 is the accept cycle. Watches 8 following cycles.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] rs1,
                       input logic [11:0] imm, input logic [31:0] sd);
    @(negedge clk);
    is_store = st; funct3 = f3; rs1_val = rs1; immediate = imm; store_data = sd;
    req_valid = 1'b1;
    acc_rdy = req_ready;
    r_cyc = -1; rv_n = 0; we_n = 0; we_cyc = -1; re_n = 0; re_cyc = -1;
    r_data = 'x; r_err = 'x; we_data = 'x; we_addr = 'x; re_addr = 'x; both_hi = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (mem_we) begin we_n++; we_cyc = c; we_addr = mem_addr; we_data = mem_wdata; end
      if (mem_re) begin re_n++; re_cyc = c; re_addr = mem_addr; end
      if (mem_we && mem_re) both_hi = 1'b1;
      if (resp_valid) begin
        rv_n++;
        if (r_cyc < 0) begin r_cyc = c; r_data = resp_data; r_err = resp_err; end
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_chk++;
    if ({req_ready, resp_valid, mem_we, mem_re} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 1000", {req_ready, resp_valid, mem_we, mem_re});
    end
    n_chk++;
    if ({resp_data, resp_err, mem_addr, mem_wdata} !== 71'd0) begin
      n_fail++; $display("FAIL reset_data got %h/%b/%h/%h want zeros", resp_data, resp_err, mem_addr, mem_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_sw;
    issue(1'b1, 3'b010, 32'h8, 12'h004, 32'hDEADBEEF);
    n_chk++;
    if (acc_rdy !== 1'b1) begin n_fail++; $display("FAIL sw_ready got %b want 1", acc_rdy); end
    n_chk++;
    if (we_n !== 1 || we_cyc !== 1) begin
      n_fail++; $display("FAIL sw_we got count %0d cycle %0d want 1/1", we_n, we_cyc);
    end
    n_chk++;
    if (we_addr !== 5'd3 || we_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL sw_wr got addr %0d data %h want 3/deadbeef", we_addr, we_data);
    end
    n_chk++;
    if (r_cyc !== 2 || rv_n !== 1 || r_err !== 2'b00 || r_data !== 32'h0) begin
      n_fail++; $display("FAIL sw_resp got cyc %0d n %0d err %b data %h want 2/1/00/0", r_cyc, rv_n, r_err, r_data);
    end
    n_chk++;
    if (re_n !== 0 || mem[3] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL sw_mem got re %0d mem3 %h want 0/deadbeef", re_n, mem[3]);
    end
  endtask

  task automatic test_loads;
    preload(5'd3, 32'hDEADBEEF);
    issue(1'b0, 3'b000, 32'hC, 12'h003, 32'h0);
    n_chk++;
    if (r_cyc !== 3 || r_data !== 32'hFFFFFFDE || r_err !== 2'b00) begin
      n_fail++; $display("FAIL lb got cyc %0d data %h err %b want 3/ffffffde/00", r_cyc, r_data, r_err);
    end
    n_chk++;
    if (re_n !== 1 || re_cyc !== 1 || re_addr !== 5'd3 || we_n !== 0) begin
      n_fail++; $display("FAIL lb_mem got re %0d@%0d addr %0d we %0d want 1@1 3 0", re_n, re_cyc, re_addr, we_n);
    end
    n_chk++;
    if (resp_data !== 32'hFFFFFFDE) begin
      n_fail++; $display("FAIL lb_hold got %h want ffffffde", resp_data);
    end
    issue(1'b0, 3'b100, 32'hC, 12'h003, 32'h0);
    n_chk++;
    if (r_cyc !== 3 || r_data !== 32'h000000DE) begin
      n_fail++; $display("FAIL lbu got cyc %0d data %h want 3/000000de", r_cyc, r_data);
    end
    issue(1'b0, 3'b101, 32'hC, 12'h000, 32'h0);
    n_chk++;
    if (r_cyc !== 3 || r_data !== 32'h0000BEEF) begin
      n_fail++; $display("FAIL lhu got cyc %0d data %h want 3/0000beef", r_cyc, r_data);
    end
    issue(1'b0, 3'b001, 32'hC, 12'h002, 32'h0);
    n_chk++;
    if (r_data !== 32'hFFFFDEAD) begin
      n_fail++; $display("FAIL lh got %h want ffffdead", r_data);
    end
    issue(1'b0, 3'b010, 32'h10, 12'hFFC, 32'h0);
    n_chk++;
    if (re_addr !== 5'd3 || r_data !== 32'hDEADBEEF || r_cyc !== 3) begin
      n_fail++; $display("FAIL lw_negimm got addr %0d data %h cyc %0d want 3/deadbeef/3", re_addr, r_data, r_cyc);
    end
  endtask

  task automatic test_sub_store;
    preload(5'd3, 32'hDEADBEEF);
    issue(1'b1, 3'b001, 32'hE, 12'h000, 32'h00001234);
    n_chk++;
    if (re_n !== 1 || re_cyc !== 1 || re_addr !== 5'd3) begin
      n_fail++; $display("FAIL sh_rd got %0d@%0d addr %0d want 1@1 3", re_n, re_cyc, re_addr);
    end
    n_chk++;
    if (we_n !== 1 || we_cyc !== 3 || we_data !== 32'h1234BEEF || we_addr !== 5'd3) begin
      n_fail++; $display("FAIL sh_wr got %0d@%0d %h addr %0d want 1@3 1234beef 3", we_n, we_cyc, we_data, we_addr);
    end
    n_chk++;
    if (r_cyc !== 4 || r_err !== 2'b00 || mem[3] !== 32'h1234BEEF || both_hi !== 1'b0) begin
      n_fail++; $display("FAIL sh_resp got cyc %0d err %b mem3 %h both %b want 4/00/1234beef/0", r_cyc, r_err, mem[3], both_hi);
    end
    issue(1'b1, 3'b000, 32'hD, 12'h000, 32'hFFFFFF77);
    n_chk++;
    if (we_cyc !== 3 || mem[3] !== 32'h1234775F && mem[3] !== 32'h123477EF) begin
      n_fail++; $display("FAIL sb got cyc %0d mem3 %h want 3/123477ef", we_cyc, mem[3]);
    end
    n_chk++;
    if (mem[3] !== 32'h123477EF) begin
      n_fail++; $display("FAIL sb_lane got %h want 123477ef", mem[3]);
    end
  endtask

  task automatic test_errors;
    logic        st [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3 [4]  = '{3'b010, 3'b010, 3'b011, 3'b001};
    logic [31:0] a  [4]  = '{32'h6, 32'h80, 32'h0, 32'h81};
    logic [1:0]  e  [4]  = '{2'b01, 2'b10, 2'b11, 2'b01};
    for (int i = 0; i < 4; i++) begin
      issue(st[i], f3[i], a[i], 12'h000, 32'hA5A5A5A5);
      n_chk++;
      if (r_cyc !== 1 || rv_n !== 1 || r_err !== e[i] || r_data !== 32'h0) begin
        n_fail++; $display("FAIL err_%0d got cyc %0d n %0d err %b data %h want 1/1/%b/0", i, r_cyc, rv_n, r_err, r_data, e[i]);
      end
      n_chk++;
      if (re_n !== 0 || we_n !== 0) begin
        n_fail++; $display("FAIL err_%0d_strobe got re %0d we %0d want 0/0", i, re_n, we_n);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic rdy [8];
    int   rc [2];
    logic [31:0] rd [2];
    int   k = 0;
    preload(5'd3, 32'h11112222);
    preload(5'd5, 32'h33334444);
    rc[0] = -1; rc[1] = -1; rd[0] = 'x; rd[1] = 'x;
    @(negedge clk);
    is_store = 1'b0; funct3 = 3'b010; rs1_val = 32'hC; immediate = '0; req_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) rs1_val = 32'h14;
      rdy[c] = req_ready;
      if (resp_valid && k < 2) begin rc[k] = c; rd[k] = resp_data; k++; end
      if (c == 7) req_valid = 1'b0;
    end
    n_chk++;
    if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0 || rdy[2] !== 1'b0 || rdy[3] !== 1'b0 || rdy[4] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready got %b%b%b%b%b want 10001", rdy[0], rdy[1], rdy[2], rdy[3], rdy[4]);
    end
    n_chk++;
    if (rc[0] !== 3 || rc[1] !== 7) begin
      n_fail++; $display("FAIL b2b_cycles got %0d/%0d want 3/7", rc[0], rc[1]);
    end
    n_chk++;
    if (rd[0] !== 32'h11112222 || rd[1] !== 32'h33334444) begin
      n_fail++; $display("FAIL b2b_data got %h/%h want 11112222/33334444", rd[0], rd[1]);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle got rdy %b rv %b want 1/0", req_ready, resp_valid);
    end
  endtask

  task automatic test_reset_mid_op;
    int we_before;
    preload(5'd3, 32'hDEADBEEF);
    we_before = we_total;
    @(negedge clk);
    is_store = 1'b1; funct3 = 3'b000; rs1_val = 32'hC; immediate = '0; store_data = 32'h55;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_chk++;
    if (mem_re !== 1'b1) begin n_fail++; $display("FAIL rst_rd got %b want 1", mem_re); end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if ({req_ready, resp_valid, mem_we, mem_re} !== 4'b1000 ||
        {resp_data, resp_err, mem_addr, mem_wdata} !== 71'd0) begin
      n_fail++; $display("FAIL rst_async got %b %h %b %h %h want 1000 zeros",
                         {req_ready, resp_valid, mem_we, mem_re}, resp_data, resp_err, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (we_total !== we_before || mem[3] !== 32'hDEADBEEF || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_abort got we %0d mem3 %h rv %b want %0d/deadbeef/0", we_total, mem[3], resp_valid, we_before);
    end
    issue(1'b0, 3'b010, 32'hC, 12'h000, 32'h0);
    n_chk++;
    if (r_cyc !== 3 || r_data !== 32'hDEADBEEF || r_err !== 2'b00) begin
      n_fail++; $display("FAIL rst_after_lw got cyc %0d data %h err %b want 3/deadbeef/00", r_cyc, r_data, r_err);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_loads();
    test_sub_store();
    test_errors();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
